bs_search_engine: RTL and testbench

//  Parametrised binary-search engine over a sorted synchronous-read memory; successor to the lab bs_controller/bs_datapath pair.

---
 rtl/bs_search_engine.sv | 128 ++++++++++++
 tb/tb_bs_search_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bs_search_engine.sv
// bs_search_engine: binary search over a sorted synchronous-read table, exact match or lower bound.
// The search window is half-open [lo,hi); each probe costs ADDR + (RD_LAT+1) WAIT + CMP cycles.
module bs_search_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  parameter int RD_LAT = 1,
  parameter int DESCEND = 0,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] target_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [ADDR_W-1:0] loc_o,
  output logic [ADDR_W:0]   probes_o
);
  typedef enum logic [2:0] {IDLE, SETUP, ADDR, WAIT, CMP, FIN, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C = (ADDR_W+1)'(1);
  state_t state_q, state_d;
  logic [ADDR_W:0] lo_q, lo_d, hi_q, hi_d, probes_q, probes_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic mode_q, mode_d, found_q, found_d;
  logic [1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, loc_q, loc_d;
  logic [ADDR_W+1:0] sum;
  logic [ADDR_W:0] mid, lo_nx, hi_nx;
  logic less, hit;
  // one extra bit in the sum keeps lo+hi from wrapping when hi == DEPTH
  assign sum = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid = sum[ADDR_W+1:1];
  assign hit = mem_rdata_i == tgt_q;
  assign less = (DESCEND != 0) ? (mem_rdata_i > tgt_q) : (mem_rdata_i < tgt_q);
  assign lo_nx = less ? mid + ONE_C : lo_q;
  assign hi_nx = less ? hi_q : mid;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      probes_q <= '0;
      tgt_q <= '0;
      mode_q <= 1'b0;
      found_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      loc_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      probes_q <= probes_d;
      tgt_q <= tgt_d;
      mode_q <= mode_d;
      found_q <= found_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      loc_q <= loc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    hi_d = hi_q;
    probes_d = probes_q;
    tgt_d = tgt_q;
    mode_d = mode_q;
    found_d = found_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    loc_d = loc_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SETUP;
        tgt_d = target_i;
        mode_d = mode_i;
        found_d = 1'b0;
        loc_d = '0;
        probes_d = '0;
      end
      SETUP: begin
        lo_d = '0;
        hi_d = DEPTH_C;
        state_d = ADDR;
      end
      ADDR: begin
        addr_d = mid[ADDR_W-1:0];
        cnt_d = 2'(RD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd0) ? CMP : WAIT;
      end
      CMP: begin
        probes_d = probes_q + ONE_C;
        if (!mode_q && hit) begin
          found_d = 1'b1;
          loc_d = mid[ADDR_W-1:0];
          state_d = DONE;
        end else begin
          lo_d = lo_nx;
          hi_d = hi_nx;
          state_d = (lo_nx == hi_nx) ? FIN : ADDR;
        end
      end
      FIN: begin
        found_d = mode_q && (lo_q < DEPTH_C);
        loc_d = (mode_q && lo_q < DEPTH_C) ? lo_q[ADDR_W-1:0] : '0;
        state_d = DONE;
      end
      DONE: state_d = start_i ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign done_o = state_q == DONE;
  assign mem_addr_o = addr_q;
  assign found_o = found_q;
  assign loc_o = loc_q;
  assign probes_o = probes_q;
endmodule

// File: tb/tb_bs_search_engine.sv
// tb_bs_search_engine: directed table, hand sequences and random searches on a 32-entry ascending table,
// plus concurrent sweeps of every target over DEPTH {1,5,32} x RD_LAT {1,3} x DESCEND {0,1}.
module tb_bs_search_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  int fin_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_val(input int d, input int ds, input int i);
    return ds != 0 ? 2 * (d - 1 - i) + 1 : 2 * i + 1;
  endfunction

  function automatic bit ref_less(input int d, input int ds, input int i, input int t);
    return ds != 0 ? ref_val(d, ds, i) > t : ref_val(d, ds, i) < t;
  endfunction

  function automatic int ref_lb(input int d, input int ds, input int t);
    for (int i = 0; i < d; i++) if (!ref_less(d, ds, i, t)) return i;
    return d;
  endfunction

  function automatic bit ref_has(input int d, input int ds, input int t);
    for (int i = 0; i < d; i++) if (ref_val(d, ds, i) == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_probes(input int d, input int ds, input int t, input bit exact);
    int lo = 0, hi = d, n = 0, mid;
    while (lo < hi) begin
      mid = (lo + hi) / 2;
      n++;
      if (exact && ref_val(d, ds, mid) == t) return n;
      if (ref_less(d, ds, mid, t)) lo = mid + 1; else hi = mid;
    end
    return n;
  endfunction

  logic d_rst_n, d_start, d_mode, d_busy, d_done, d_found;
  logic [7:0] d_target, d_rdata;
  logic [4:0] d_addr, d_loc;
  logic [5:0] d_probes;

  bs_search_engine #(.DATA_W(8), .DEPTH(32), .RD_LAT(1), .DESCEND(0)) dut (
    .clk_i(clk), .reset_n_i(d_rst_n), .start_i(d_start), .mode_i(d_mode), .target_i(d_target),
    .mem_addr_o(d_addr), .mem_rdata_i(d_rdata), .busy_o(d_busy), .done_o(d_done),
    .found_o(d_found), .loc_o(d_loc), .probes_o(d_probes)
  );

  always @(posedge clk) d_rdata <= 8'(ref_val(32, 0, int'(d_addr)));

  task automatic d_run(input bit m, input int t, input bit hold, output int cyc, output bit busy_ok);
    @(negedge clk);
    d_mode = m;
    d_target = 8'(t);
    d_start = 1'b1;
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!hold) d_start = 1'b0;
      d_target = 8'($urandom);
      d_mode = 1'($urandom);
      if (d_done) break;
      if (!d_busy) busy_ok = 1'b0;
    end
    if (!d_done) chk("d_timeout", 0, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {bit m; int t; int f; int loc; int p;} vec_t;
  vec_t vecs[8];

  initial begin
    int cyc, lb, p, w;
    bit bok, hs, m;
    int t;
    vecs[0] = '{0, 41, 1, 20, 3};
    vecs[1] = '{0, 40, 0, 0, 5};
    vecs[2] = '{1, 40, 1, 20, 5};
    vecs[3] = '{1, 0, 1, 0, 6};
    vecs[4] = '{1, 64, 0, 0, 5};
    vecs[5] = '{0, 1, 1, 0, 6};
    vecs[6] = '{0, 63, 1, 31, 5};
    vecs[7] = '{0, 64, 0, 0, 5};
    d_rst_n = 1'b0;
    d_start = 1'b0;
    d_mode = 1'b0;
    d_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({d_addr, d_busy, d_done, d_found, d_loc, d_probes}), 0);
    @(negedge clk) d_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_run(vecs[i].m, vecs[i].t, 1'b0, cyc, bok);
      chk($sformatf("vec%0d_found", i), int'(d_found), vecs[i].f);
      chk($sformatf("vec%0d_loc", i), int'(d_loc), vecs[i].loc);
      chk($sformatf("vec%0d_probes", i), int'(d_probes), vecs[i].p);
      chk($sformatf("vec%0d_cycles", i), cyc, 2 + 4 * vecs[i].p + ((!vecs[i].m && vecs[i].f == 1) ? 0 : 1));
      chk($sformatf("vec%0d_busy", i), int'(bok), 1);
    end
    // start held past completion must not relaunch the search
    d_run(1'b0, 41, 1'b1, cyc, bok);
    w = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!d_done || d_busy || d_probes != 6'd3) w++;
    end
    chk("hold_done_cycles_bad", w, 0);
    @(negedge clk) d_start = 1'b0;
    @(posedge clk);
    #1;
    chk("release_done", int'(d_done), 0);
    @(posedge clk);
    #1;
    chk("release_idle_busy", int'(d_busy), 0);
    // reset pulse while waiting on the third probe's read data
    @(negedge clk);
    d_mode = 1'b0;
    d_target = 8'd40;
    d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_probes", int'(d_probes), 2);
    chk("rst_mid_busy", int'(d_busy), 1);
    d_rst_n = 1'b0;
    #1;
    chk("rst_low_now", int'({d_addr, d_busy, d_done, d_found, d_loc, d_probes}), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_low_held", int'({d_addr, d_busy, d_done, d_found, d_loc, d_probes}), 0);
    @(negedge clk) d_rst_n = 1'b1;
    d_run(1'b1, 40, 1'b0, cyc, bok);
    chk("after_rst_found", int'(d_found), 1);
    chk("after_rst_loc", int'(d_loc), 20);
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 70));
      m = 1'($urandom_range(0, 1));
      d_run(m, t, 1'b0, cyc, bok);
      hs = ref_has(32, 0, t);
      lb = ref_lb(32, 0, t);
      p = ref_probes(32, 0, t, !m);
      chk($sformatf("rnd%0d_t%0d_m%0d_found", i, t, m), int'(d_found), m ? int'(lb < 32) : int'(hs));
      chk($sformatf("rnd%0d_t%0d_m%0d_loc", i, t, m), int'(d_loc), (m && lb < 32) ? lb : (!m && hs) ? (t - 1) / 2 : 0);
      chk($sformatf("rnd%0d_t%0d_m%0d_probes", i, t, m), int'(d_probes), p);
    end
    w = 0;
    while (fin_cnt < 12 && w < 50000) begin
      @(posedge clk);
      w++;
    end
    chk("sweeps_finished", fin_cnt, 12);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  for (genvar g = 0; g < 12; g++) begin : cfg
    localparam int D = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 5 : 32;
    localparam int L = ((g / 3) % 2 != 0) ? 3 : 1;
    localparam int DS = g / 6;
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    logic rst_n, start, mode, busy, done, found;
    logic [7:0] target, rdata;
    logic [7:0] pipe [3];
    logic [AW-1:0] addr, loc;
    logic [AW:0] probes;

    bs_search_engine #(.DATA_W(8), .DEPTH(D), .RD_LAT(L), .DESCEND(DS)) sdut (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .mode_i(mode), .target_i(target),
      .mem_addr_o(addr), .mem_rdata_i(rdata), .busy_o(busy), .done_o(done),
      .found_o(found), .loc_o(loc), .probes_o(probes)
    );

    always @(posedge clk) begin
      pipe[0] <= 8'(ref_val(D, DS, int'(addr)));
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rdata = pipe[L-1];

    initial begin
      int cyc, lb, p;
      bit hs;
      rst_n = 1'b0;
      start = 1'b0;
      mode = 1'b0;
      target = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t <= 2 * D + 1; t++) begin
        for (int m = 0; m < 2; m++) begin
          @(negedge clk);
          mode = 1'(m);
          target = 8'(t);
          start = 1'b1;
          cyc = 0;
          while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            target = 8'($urandom);
            mode = 1'($urandom);
            if (done) break;
          end
          if (!done) chk($sformatf("c%0d_timeout", g), 0, 1);
          hs = ref_has(D, DS, t);
          lb = ref_lb(D, DS, t);
          p = ref_probes(D, DS, t, m == 0);
          chk($sformatf("c%0d_t%0d_m%0d_found", g, t, m), int'(found), m != 0 ? int'(lb < D) : int'(hs));
          if (m == 0 && hs) chk($sformatf("c%0d_t%0d_m%0d_locval", g, t, m), ref_val(D, DS, int'(loc)), t);
          else chk($sformatf("c%0d_t%0d_m%0d_loc", g, t, m), int'(loc), (m != 0 && lb < D) ? lb : 0);
          chk($sformatf("c%0d_t%0d_m%0d_probes", g, t, m), int'(probes), p);
          chk($sformatf("c%0d_t%0d_m%0d_cycles", g, t, m), cyc, 2 + p * (L + 3) + ((m == 0 && hs) ? 0 : 1));
          @(posedge clk);
          #1;
        end
      end
      fin_cnt++;
    end
  end
endmodule
